alu_seq: RTL

Multi-cycle, parametrised successor to the calculator ALU. It holds two operand registers loaded from the switch input and runs add, subtract, multiply and scaled divide (A·100/B) under a start/busy/done handshake. Multiply uses an iterative shift-add datapath and divide a restoring divider, so wide operands close timing. It sits between the switch/button front end and the indicator driver. Its `result` and `control` outputs replace the old single-cycle `ind_1` and `control`.

---
 rtl/alu_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU (add, sub, shift-add multiply, restoring A*100/B divide) with a
// start/busy/done handshake. Define ALU_SEQ_DIV_EN to build the scaled divider.
module alu_seq #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned RES_W   = 22,
    parameter int unsigned ARIF    = 4,
    parameter int unsigned CONTROL = 3
) (
    input  logic               clk_ALU,
    input  logic               rst_n_ALU,
    input  logic [WIDTH-1:0]   in_numb,
    input  logic [1:0]         keys,
    input  logic [ARIF-1:0]    arif,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [RES_W-1:0]   result,
    output logic [CONTROL-1:0] control
);

    localparam int unsigned      CNT_W   = $clog2(RES_W + 1);
    localparam logic [CNT_W-1:0] MulLast = CNT_W'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [CNT_W-1:0] DivLast = CNT_W'(RES_W - 1);
`endif

    localparam logic [CONTROL-1:0] CtlPos     = CONTROL'(0);
    localparam logic [CONTROL-1:0] CtlNeg     = CONTROL'(1);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [CONTROL-1:0] CtlDivZero = CONTROL'(2);
    localparam logic [CONTROL-1:0] CtlQuot    = CONTROL'(4);
`endif
    localparam logic [CONTROL-1:0] CtlIll     = CONTROL'(7);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StMul      = 3'd1,
`ifdef ALU_SEQ_DIV_EN
        StDivSetup = 3'd2,
        StDiv      = 3'd3,
`endif
        StFinish   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OpAdd     = 3'd0,
        OpSub     = 3'd1,
        OpMul     = 3'd2,
        OpPass    = 3'd3,
`ifdef ALU_SEQ_DIV_EN
        OpDiv     = 3'd5,
        OpDivZero = 3'd6,
`endif
        OpIll     = 3'd4
    } op_e;

    state_e state_q, state_d;
    op_e    op_dec, op_q;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   op_a_q, op_b_q, pass_q;
    logic [CNT_W-1:0]   cnt_q;
    // acc_q holds the product during MUL and the dividend/quotient during DIV.
    logic [RES_W-1:0]   acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [RES_W-1:0]   result_q, result_d;
    logic [CONTROL-1:0] control_q, control_d;
    logic               done_q, done_d;
    logic               start_acc;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_nxt;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
`endif

    assign start_acc = (state_q == StIdle) && start;

    // Opcode decode; the divide-by-zero decision uses the pre-edge B that gets snapshotted.
    always_comb begin
        op_dec = OpIll;
        unique case (arif)
            ARIF'(4'b1110): op_dec = OpAdd;
            ARIF'(4'b1101): op_dec = OpSub;
            ARIF'(4'b1011): op_dec = OpMul;
            ARIF'(4'b1111): op_dec = OpPass;
`ifdef ALU_SEQ_DIV_EN
            ARIF'(4'b0111): op_dec = (b_q == '0) ? OpDivZero : OpDiv;
`endif
            default:        op_dec = OpIll;
        endcase
    end

    always_ff @(posedge clk_ALU or negedge rst_n_ALU) begin
        if (!rst_n_ALU) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (keys == 2'b10) a_q <= in_numb;
            if (keys == 2'b01) b_q <= in_numb;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    always_comb begin
        div_trial = {rem_q, acc_q[RES_W-1]};
        div_ge    = div_trial >= {1'b0, op_b_q};
        rem_nxt   = div_ge ? WIDTH'(div_trial - {1'b0, op_b_q}) : div_trial[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk_ALU or negedge rst_n_ALU) begin
        if (!rst_n_ALU) begin
            op_q     <= OpIll;
            op_a_q   <= '0;
            op_b_q   <= '0;
            pass_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem_q    <= '0;
`endif
        end else if (start_acc) begin
            op_q     <= op_dec;
            op_a_q   <= a_q;
            op_b_q   <= b_q;
            pass_q   <= in_numb;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= RES_W'(a_q);
            mplier_q <= b_q;
        end else begin
            case (state_q)
                StMul: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
`ifdef ALU_SEQ_DIV_EN
                StDivSetup: begin
                    acc_q <= (RES_W'(op_a_q) << 6) + (RES_W'(op_a_q) << 5)
                           + (RES_W'(op_a_q) << 2);
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                StDiv: begin
                    acc_q <= {acc_q[RES_W-2:0], div_ge};
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_ALU or negedge rst_n_ALU) begin
        if (!rst_n_ALU) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op_dec)
                        OpMul:   state_d = StMul;
`ifdef ALU_SEQ_DIV_EN
                        OpDiv:   state_d = StDivSetup;
`endif
                        default: state_d = StFinish;
                    endcase
                end
            end
            StMul:      if (cnt_q == MulLast) state_d = StFinish;
`ifdef ALU_SEQ_DIV_EN
            StDivSetup: state_d = StDiv;
            StDiv:      if (cnt_q == DivLast) state_d = StFinish;
`endif
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        control_d = control_q;
        done_d    = 1'b0;
        busy      = (state_q != StIdle);
        if (state_q == StFinish) begin
            done_d = 1'b1;
            case (op_q)
                OpAdd: begin
                    result_d  = RES_W'({1'b0, op_a_q} + {1'b0, op_b_q});
                    control_d = CtlPos;
                end
                OpSub: begin
                    if (op_a_q < op_b_q) begin
                        result_d  = RES_W'(op_b_q - op_a_q);
                        control_d = CtlNeg;
                    end else begin
                        result_d  = RES_W'(op_a_q - op_b_q);
                        control_d = CtlPos;
                    end
                end
                OpMul: begin
                    result_d  = acc_q;
                    control_d = CtlPos;
                end
                OpPass: begin
                    result_d  = RES_W'(pass_q);
                    control_d = CtlPos;
                end
`ifdef ALU_SEQ_DIV_EN
                OpDiv: begin
                    result_d  = acc_q;
                    control_d = CtlQuot;
                end
                OpDivZero: control_d = CtlDivZero;
`endif
                default: begin
                    result_d  = '0;
                    control_d = CtlIll;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ALU or negedge rst_n_ALU) begin
        if (!rst_n_ALU) begin
            result_q  <= '0;
            control_q <= '0;
            done_q    <= 1'b0;
        end else begin
            result_q  <= result_d;
            control_q <= control_d;
            done_q    <= done_d;
        end
    end

    assign result  = result_q;
    assign control = control_q;
    assign done    = done_q;

endmodule
